// File: rtl/sonar_pkg.sv
// Sonar shared definitions: FSM states, timing
// constants, angle table, ASCII codes, helpers.
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_TRIG      = 3'd2,
    S_WAIT_ECHO = 3'd3,
    S_MEASURE   = 3'd4,
    S_TX        = 3'd5,
    S_STEP      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam int unsigned TRIG_CLKS    = 500;
  localparam int unsigned HALF_CM_CLKS = 1471;
  localparam int unsigned CM_CLKS      = 2941;
  localparam int unsigned BAUD_CLKS    = 434;
  localparam int unsigned PWM_PER_CLKS = 1_000_000;
  localparam int unsigned PWM_BASE_CLKS = 50_000;
  localparam int unsigned PWM_STEP_CLKS = 7_143;
  localparam int unsigned ECHO_TO_CLKS = 2_500_000;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  function automatic logic [11:0] angle_bcd(
    input logic [2:0] idx
  );
    logic [11:0] a;
    unique case (idx)
      3'd0: a = 12'h020;
      3'd1: a = 12'h040;
      3'd2: a = 12'h060;
      3'd3: a = 12'h080;
      3'd4: a = 12'h100;
      3'd5: a = 12'h120;
      3'd6: a = 12'h140;
      default: a = 12'h160;
    endcase
    return a;
  endfunction

  // Saturating 3-digit BCD increment.
  function automatic logic [11:0] bcd_inc(
    input logic [11:0] v
  );
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v != 12'h999) begin
      if (d0 != 4'd9) d0 = d0 + 4'd1;
      else begin
        d0 = 4'd0;
        if (d1 != 4'd9) d1 = d1 + 4'd1;
        else begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex7(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sonar_uart_tx.sv
// 8N1 UART transmitter; a start on the done cycle
// chains the next frame with no idle gap.
// Ports: i_clk, i_rst, i_byte, i_start, o_busy, o_done, o_tx.
module sonar_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  logic        r_busy;
  logic [31:0] r_div;
  logic [3:0]  r_bit;
  logic [9:0]  r_sh;
  logic        w_tick;
  logic        w_load;

  assign w_tick = r_busy && (r_div == BAUD_DIV - 1);
  assign o_done = w_tick && (r_bit == 4'd9);
  assign w_load = i_start && (!r_busy || o_done);
  assign o_busy = r_busy;
  assign o_tx   = r_busy ? r_sh[0] : 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_div  <= '0;
      r_bit  <= '0;
      r_sh   <= '1;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_div  <= '0;
      r_bit  <= '0;
      r_sh   <= {1'b1, i_byte, 1'b0};
    end else if (r_busy) begin
      if (w_tick) begin
        r_div <= '0;
        if (r_bit == 4'd9) r_busy <= 1'b0;
        else begin
          r_bit <= r_bit + 4'd1;
          r_sh  <= {1'b1, r_sh[9:1]};
        end
      end else begin
        r_div <= r_div + 32'd1;
      end
    end
  end

endmodule

// File: rtl/sonar.sv
// Sonar sweep: trigger, echo ranging, UART report,
// servo PWM stepping and seven-segment display.
// Ports: clock, reset, ligar, echo, display_mode in;
// trigger, pwm, saida_serial, fim_posicao, hex0..hex5,
// db_fim_transmissao, db_fim_posicao, db_saida_serial out.
module sonar
  import sonar_pkg::*;
#(
  parameter int unsigned CLKS_PER_CM  = CM_CLKS,
  parameter int unsigned BAUD_DIV     = BAUD_CLKS,
  parameter int unsigned ECHO_TIMEOUT = ECHO_TO_CLKS,
  parameter int unsigned PWM_PERIOD   = PWM_PER_CLKS,
  parameter int unsigned PWM_BASE     = PWM_BASE_CLKS,
  parameter int unsigned PWM_STEP     = PWM_STEP_CLKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       echo,
  input  logic       display_mode,
  output logic       trigger,
  output logic       pwm,
  output logic       saida_serial,
  output logic       fim_posicao,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       db_fim_transmissao,
  output logic       db_fim_posicao,
  output logic       db_saida_serial
);

  // Rounding: first cm after half a cm of echo.
  localparam int unsigned HALF = (CLKS_PER_CM + 1) / 2;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic        r_first;
  logic [11:0] r_dist;
  logic [2:0]  r_idx;
  logic        r_dn;
  logic [2:0]  r_ch;
  logic        r_echo_s;
  logic        r_echo_d;
  logic        r_fim_tx;
  logic [31:0] r_pcnt;
  logic [31:0] r_width;

  logic        w_rise;
  logic [31:0] w_lim;
  logic [11:0] w_ang;
  logic        w_busy;
  logic        w_done;
  logic        w_last;
  logic        w_start;
  logic [2:0]  w_sel;
  logic [7:0]  w_byte;
  logic        w_tx;

  assign w_rise  = r_echo_s && !r_echo_d;
  assign w_lim   = r_first ? HALF : CLKS_PER_CM;
  assign w_ang   = angle_bcd(r_idx);
  assign w_last  = w_done && (r_ch == 3'd7);
  assign w_start = (r_state == S_TX) &&
                   (!w_busy || (w_done && !w_last));
  assign w_sel   = w_done ? r_ch + 3'd1 : r_ch;

  always_comb begin
    w_byte = ASCII_HASH;
    unique case (w_sel)
      3'd0: w_byte = ASCII_ZERO + {4'h0, w_ang[11:8]};
      3'd1: w_byte = ASCII_ZERO + {4'h0, w_ang[7:4]};
      3'd2: w_byte = ASCII_ZERO + {4'h0, w_ang[3:0]};
      3'd3: w_byte = ASCII_COMMA;
      3'd4: w_byte = ASCII_ZERO + {4'h0, r_dist[11:8]};
      3'd5: w_byte = ASCII_ZERO + {4'h0, r_dist[7:4]};
      3'd6: w_byte = ASCII_ZERO + {4'h0, r_dist[3:0]};
      default: w_byte = ASCII_HASH;
    endcase
  end

  sonar_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_byte (w_byte),
    .i_start(w_start),
    .o_busy (w_busy),
    .o_done (w_done),
    .o_tx   (w_tx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (ligar) w_next = S_CLEAR;
      S_CLEAR: w_next = S_TRIG;
      S_TRIG:
        if (r_cnt == TRIG_CLKS - 1)
          w_next = S_WAIT_ECHO;
      S_WAIT_ECHO:
        if (w_rise) w_next = S_MEASURE;
        else if (r_cnt == ECHO_TIMEOUT - 1)
          w_next = S_TX;
      S_MEASURE: if (!r_echo_s) w_next = S_TX;
      S_TX:      if (w_last) w_next = S_STEP;
      S_STEP:    w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_first  <= 1'b1;
      r_dist   <= '0;
      r_idx    <= '0;
      r_dn     <= 1'b0;
      r_ch     <= '0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
      r_fim_tx <= 1'b0;
    end else begin
      r_echo_s <= echo;
      r_echo_d <= r_echo_s;
      r_fim_tx <= (r_state == S_TX) && w_last;
      unique case (r_state)
        S_CLEAR: begin
          r_cnt  <= '0;
          r_dist <= '0;
          r_ch   <= '0;
        end
        S_TRIG:
          if (r_cnt == TRIG_CLKS - 1) r_cnt <= '0;
          else r_cnt <= r_cnt + 32'd1;
        S_WAIT_ECHO:
          if (w_rise) begin
            r_cnt   <= 32'd1;
            r_first <= 1'b1;
          end else if (r_cnt == ECHO_TIMEOUT - 1) begin
            r_dist <= 12'h999;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        S_MEASURE:
          if (r_echo_s) begin
            if (r_cnt == w_lim - 1) begin
              r_cnt   <= '0;
              r_first <= 1'b0;
              r_dist  <= bcd_inc(r_dist);
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        S_TX:
          if (w_done && !w_last) r_ch <= r_ch + 3'd1;
        S_STEP:
          if (!r_dn) begin
            if (r_idx == 3'd7) begin
              r_idx <= 3'd6;
              r_dn  <= 1'b1;
            end else r_idx <= r_idx + 3'd1;
          end else begin
            if (r_idx == 3'd0) begin
              r_idx <= 3'd1;
              r_dn  <= 1'b0;
            end else r_idx <= r_idx - 3'd1;
          end
        default: ;
      endcase
    end
  end

  // Width is latched at period end so a change never truncates a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_width <= PWM_BASE;
    end else if (r_pcnt == PWM_PERIOD - 1) begin
      r_pcnt  <= '0;
      r_width <= PWM_BASE + PWM_STEP * {29'd0, r_idx};
    end else begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  assign pwm                = r_pcnt < r_width;
  assign trigger            = r_state == S_TRIG;
  assign fim_posicao        = r_state == S_STEP;
  assign saida_serial       = w_tx;
  assign db_fim_transmissao = r_fim_tx;
  assign db_fim_posicao     = fim_posicao;
  assign db_saida_serial    = w_tx;

  always_comb begin
    if (display_mode) begin
      hex0 = hex7({1'b0, r_state});
      hex1 = hex7({1'b0, r_ch});
      hex2 = 7'h7F;
      hex3 = 7'h7F;
      hex4 = 7'h7F;
      hex5 = 7'h7F;
    end else begin
      hex0 = hex7(r_dist[3:0]);
      hex1 = hex7(r_dist[7:4]);
      hex2 = hex7(r_dist[11:8]);
      hex3 = hex7(w_ang[3:0]);
      hex4 = hex7(w_ang[7:4]);
      hex5 = hex7(w_ang[11:8]);
    end
  end

endmodule

// File: tb/tb_sonar.sv
// Directed bench for sonar with shortened timing
// parameters and a UART receive monitor.
module tb_sonar;

  localparam int CPC = 20;
  localparam int BD  = 4;
  localparam int ETO = 3000;
  localparam int PP  = 2000;
  localparam int PB  = 100;
  localparam int PS  = 10;

  logic clock = 0;
  logic reset = 1;
  logic ligar = 0;
  logic echo = 0;
  logic display_mode = 0;
  logic trigger, pwm, saida_serial, fim_posicao;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic db_fim_transmissao, db_fim_posicao;
  logic db_saida_serial;

  int total = 0;
  int bad = 0;
  logic [7:0] rxq[$];

  sonar #(
    .CLKS_PER_CM(CPC), .BAUD_DIV(BD),
    .ECHO_TIMEOUT(ETO), .PWM_PERIOD(PP),
    .PWM_BASE(PB), .PWM_STEP(PS)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .echo(echo), .display_mode(display_mode),
    .trigger(trigger), .pwm(pwm),
    .saida_serial(saida_serial),
    .fim_posicao(fim_posicao),
    .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .db_fim_transmissao(db_fim_transmissao),
    .db_fim_posicao(db_fim_posicao),
    .db_saida_serial(db_saida_serial)
  );

  always #10 clock = ~clock;

  int m_cnt = 0;
  bit m_on = 0;
  logic [7:0] m_sh = 0;

  always @(negedge clock) begin
    if (reset) m_on = 0;
    else if (!m_on) begin
      if (!saida_serial) begin
        m_on = 1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt % BD == 1 && m_cnt > BD && m_cnt < 9 * BD)
        m_sh = {saida_serial, m_sh[7:1]};
      if (m_cnt == 9 * BD + 1) begin
        m_on = 0;
        rxq.push_back(saida_serial ? m_sh : 8'h00);
      end
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
          7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
          7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_disp(input logic [11:0] d,
                          input logic [11:0] a);
    chk("hex0", {25'd0, hex0}, {25'd0, seg(d[3:0])});
    chk("hex1", {25'd0, hex1}, {25'd0, seg(d[7:4])});
    chk("hex2", {25'd0, hex2}, {25'd0, seg(d[11:8])});
    chk("hex3", {25'd0, hex3}, {25'd0, seg(a[3:0])});
    chk("hex4", {25'd0, hex4}, {25'd0, seg(a[7:4])});
    chk("hex5", {25'd0, hex5}, {25'd0, seg(a[11:8])});
  endtask

  task automatic measure_pwm(input int exp_hi);
    int hi, lo, k;
    hi = 0; lo = 0; k = 0;
    while (pwm && k < 3 * PP) begin step(1); k++; end
    while (!pwm && k < 3 * PP) begin step(1); k++; end
    while (pwm && hi < 2 * PP) begin step(1); hi++; end
    while (!pwm && lo < 2 * PP) begin step(1); lo++; end
    chk("pwm_high", hi, exp_hi);
    chk("pwm_period", hi + lo, PP);
  endtask

  task automatic start_trig();
    int k;
    k = 0;
    ligar = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (trigger) k++;
    end
    ligar = 0;
    while (trigger && k < 1000) begin
      step(1);
      if (trigger) k++;
    end
    chk("trig_width", k, 500);
  endtask

  task automatic run_cycle(input int n_echo,
                           input logic [63:0] exp,
                           input bit poke);
    int k;
    logic [31:0] obs;
    rxq.delete();
    start_trig();
    if (n_echo > 0) begin
      step(20);
      echo = 1;
      step(n_echo);
      echo = 0;
    end
    k = 0;
    while (saida_serial && k < ETO + 200) begin
      step(1); k++;
    end
    chk("tx_start", {31'd0, saida_serial}, 0);
    if (poke) begin
      step(10);
      display_mode = 1;
      #1;
      chk("dbg_tx_state", {25'd0, hex0}, {25'd0, seg(4'd5)});
      display_mode = 0;
      ligar = 1;
      step(3);
      ligar = 0;
    end
    k = 0;
    while (!db_fim_transmissao && k < 1000) begin
      step(1); k++;
    end
    chk("fim_tx", {31'd0, db_fim_transmissao}, 1);
    chk("fim_pos", {31'd0, fim_posicao}, 1);
    step(1);
    chk("fim_pos_end", {31'd0, fim_posicao}, 0);
    chk("rx_count", rxq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      obs = (i < rxq.size()) ? {24'd0, rxq[i]} : '1;
      chk("rx_char", obs, {24'd0, exp[63 - 8 * i -: 8]});
    end
    if (poke) begin
      step(20);
      chk("ligar_ignored", {31'd0, trigger}, 0);
      display_mode = 1;
      #1;
      chk("dbg_idle", {25'd0, hex0}, {25'd0, seg(4'd0)});
      display_mode = 0;
    end
    step(2);
  endtask

  initial begin
    int k;
    step(3);
    chk("rst_trig", {31'd0, trigger}, 0);
    chk("rst_ser", {31'd0, saida_serial}, 1);
    chk("rst_dbser", {31'd0, db_saida_serial}, 1);
    chk("rst_fim", {31'd0, fim_posicao}, 0);
    chk("rst_dbfim", {31'd0, db_fim_posicao}, 0);
    chk("rst_fimtx", {31'd0, db_fim_transmissao}, 0);
    chk_disp(12'h000, 12'h020);
    reset = 0;
    step(2);
    display_mode = 1;
    #1;
    chk("dbg_h0", {25'd0, hex0}, {25'd0, seg(4'd0)});
    chk("dbg_h1", {25'd0, hex1}, {25'd0, seg(4'd0)});
    chk("dbg_h2", {25'd0, hex2}, 32'h7F);
    chk("dbg_h3", {25'd0, hex3}, 32'h7F);
    chk("dbg_h4", {25'd0, hex4}, 32'h7F);
    chk("dbg_h5", {25'd0, hex5}, 32'h7F);
    display_mode = 0;
    measure_pwm(PB);

    run_cycle(2000, "020,100#", 0);
    chk_disp(12'h100, 12'h040);
    run_cycle(1500, "040,075#", 1);
    chk_disp(12'h075, 12'h060);
    run_cycle(3400, "060,170#", 0);
    chk_disp(12'h170, 12'h080);
    run_cycle(0, "080,999#", 0);
    chk_disp(12'h999, 12'h100);
    run_cycle(9, "100,000#", 0);
    chk_disp(12'h000, 12'h120);
    run_cycle(10, "120,001#", 0);
    chk_disp(12'h001, 12'h140);
    run_cycle(30, "140,002#", 0);
    chk_disp(12'h002, 12'h160);
    measure_pwm(PB + 7 * PS);
    run_cycle(100, "160,005#", 0);
    chk_disp(12'h005, 12'h140);
    run_cycle(20, "140,001#", 0);
    chk_disp(12'h001, 12'h120);

    start_trig();
    step(20);
    echo = 1;
    step(100);
    echo = 0;
    k = 0;
    while (saida_serial && k < 500) begin
      step(1); k++;
    end
    step(15);
    reset = 1;
    #1;
    chk("rst_midtx_ser", {31'd0, saida_serial}, 1);
    step(1);
    chk_disp(12'h000, 12'h020);
    reset = 0;
    step(1);
    display_mode = 1;
    #1;
    chk("rst_idle", {25'd0, hex0}, {25'd0, seg(4'd0)});
    display_mode = 0;
    step(200);
    chk("rst_quiet", {31'd0, saida_serial}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
